// File: rtl/fetch_controller.sv
// fetch_controller
// Sequences a 16x16 synchronous instruction memory. In IDLE the memory port
// belongs to the program loader. In RUN the controller fetches sequentially
// from a 4-bit PC. A small circular instruction queue hides the memory's
// one-cycle read latency. A valid/ready handshake feeds the issue stage.
// Fetch stops on an all-zero word: the queue drains, then done pulses once.

module fetch_controller #(
    parameter int QDEPTH = 4
) (
    input  logic        Clock,
    input  logic        Reset,
    input  logic        start,
    input  logic [3:0]  start_pc,
    input  logic        redirect,
    input  logic [3:0]  redirect_pc,
    input  logic        load_valid,
    input  logic [3:0]  load_addr,
    input  logic [15:0] load_data,
    output logic        load_ready,
    output logic [3:0]  mem_Address,
    output logic        mem_Wren,
    output logic [15:0] mem_Din,
    input  logic [15:0] mem_Q,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] out_instr,
    output logic [3:0]  out_pc,
    output logic        busy,
    output logic        done
);

    // Pointer width and occupancy-count width for the queue.
    localparam int PW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
    localparam int CW = $clog2(QDEPTH + 1);
    localparam logic [CW:0]   QD_LIMIT = (CW + 1)'(QDEPTH);
    localparam logic [PW-1:0] LAST_PTR = PW'(QDEPTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t         state;
    logic [3:0]     pc;          // next address to fetch
    logic           pend;        // a read issued last cycle arrives on mem_Q now
    logic [3:0]     pend_pc;     // address of that in-flight read
    logic [CW-1:0]  count;       // queue occupancy
    logic [PW-1:0]  head;
    logic [PW-1:0]  tail;
    logic           done_r;

    logic [15:0]    q_instr [QDEPTH];
    logic [3:0]     q_pc    [QDEPTH];

    logic           active;
    logic           redirect_go;
    logic           credit;
    logic           issue;
    logic           capture;
    logic           zero_word;
    logic           enq;
    logic           deq;
    logic           not_empty;

    // Advance a queue pointer. The wrap is explicit so that depths which
    // are not powers of two also work.
    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == LAST_PTR) ? '0 : p + 1'b1;
    endfunction

    // ------------------------------------------------------------------
    // Control decode
    // ------------------------------------------------------------------
    assign active      = (state != IDLE);
    assign redirect_go = redirect && active;
    assign not_empty   = (count != '0);

    // A read may issue only if every queued entry plus the one in flight
    // leaves room. Because of this, the queue can never overflow.
    assign credit    = ({1'b0, count} + {{CW{1'b0}}, pend}) < QD_LIMIT;
    assign issue     = (state == RUN) && !redirect && credit;

    // A redirect drops whatever read is arriving in the same cycle.
    assign capture   = pend && !redirect_go;
    assign zero_word = capture && (mem_Q == 16'd0);
    assign enq       = capture && !zero_word;

    assign out_valid = not_empty && !redirect_go;
    assign deq       = out_valid && out_ready;

    // ------------------------------------------------------------------
    // Memory port and output muxing
    // ------------------------------------------------------------------
    assign load_ready  = (state == IDLE) && !Reset;
    assign mem_Wren    = load_ready && load_valid;
    assign mem_Address = (state == IDLE) ? load_addr : pc;
    assign mem_Din     = load_data;

    assign out_instr   = not_empty ? q_instr[head] : 16'd0;
    assign out_pc      = not_empty ? q_pc[head]    : 4'd0;
    assign busy        = active;
    assign done        = done_r;

    // ------------------------------------------------------------------
    // Sequencing FSM with a registered done pulse
    // ------------------------------------------------------------------
    // Sequencing FSM: IDLE -> RUN -> DRAIN -> IDLE, with redirect back to RUN.
    // NOTE: sequential state always uses non-blocking (<=) assignment, so
    // every flop samples the pre-edge values regardless of statement order.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state  <= IDLE;
            done_r <= 1'b0;
        end else begin
            done_r <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) state <= RUN;
                end
                RUN: begin
                    if (redirect_go)    state <= RUN;
                    else if (zero_word) state <= DRAIN;
                end
                DRAIN: begin
                    if (redirect_go) begin
                        state <= RUN;
                    end else if (!not_empty) begin
                        state  <= IDLE;
                        done_r <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Fetch datapath: PC and in-flight read tracking
    // ------------------------------------------------------------------
    // PC update and in-flight read tracking.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            pc      <= 4'd0;
            pend    <= 1'b0;
            pend_pc <= 4'd0;
        end else begin
            if (state == IDLE) begin
                if (start) pc <= start_pc;
            end else if (redirect_go) begin
                pc <= redirect_pc;
            end else if (issue) begin
                pc <= pc + 4'd1;
            end
            // A read that issues in the cycle a zero word lands is past the
            // end of the program, so it is never marked as pending.
            pend    <= issue && !zero_word;
            pend_pc <= pc;
        end
    end

    // ------------------------------------------------------------------
    // Instruction queue
    // ------------------------------------------------------------------
    // Queue pointers and occupancy; a redirect empties the queue.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (redirect_go) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (enq) tail <= next_ptr(tail);
            if (deq) head <= next_ptr(head);
            case ({enq, deq})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Queue storage: the captured word and the PC it was fetched from.
    // NOTE: the storage array is deliberately left out of reset. The
    // occupancy count alone defines which entries are meaningful, and the
    // outputs are masked while the queue is empty.
    always_ff @(posedge Clock) begin
        if (enq && !Reset) begin
            q_instr[tail] <= mem_Q;
            q_pc[tail]    <= pend_pc;
        end
    end

endmodule
